// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at issue and held pending until the busy window expires.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rsel,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic            state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     phi_q, phi_d, plo_q, plo_d;

    logic [63:0] prod;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic        retire, accept;

    // Both multiplies are done as 64-bit products of extended operands.
    always_comb begin
        if (op == OpMult) begin
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        end else begin
            prod = {32'b0, A} * {32'b0, B};
        end
    end

    // Signed divide on magnitudes; quotient truncates, remainder follows the dividend.
    always_comb begin
        div_signed = (op == OpDiv);
        a_mag      = (div_signed && A[31]) ? -A : A;
        b_mag      = (div_signed && B[31]) ? -B : B;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem        = (div_signed && A[31]) ? -r_mag : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;

        retire = (state_q == StRun) && (cnt_q == CntW'(1));
        accept = (state_q == StIdle) || retire;

        if (state_q == StRun) begin
            cnt_d = cnt_q - CntW'(1);
            if (retire) begin
                hi_d    = phi_q;
                lo_d    = plo_q;
                state_d = StIdle;
            end
        end

        // Issue sees post-retire HI/LO, so MTHI/MTLO override a same-edge retire.
        if (start && accept) begin
            case (op)
                OpMult, OpMultu: begin
                    phi_d   = prod[63:32];
                    plo_d   = prod[31:0];
                    cnt_d   = CntW'(MULT_CYCLES);
                    state_d = StRun;
                end
                OpDiv, OpDivu: begin
                    if (B == 32'd0) begin
                        phi_d = hi_d;
                        plo_d = lo_d;
                    end else begin
                        phi_d = rem;
                        plo_d = quo;
                    end
                    cnt_d   = CntW'(DIV_CYCLES);
                    state_d = StRun;
                end
                OpMthi:  hi_d = A;
                OpMtlo:  lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign rdata = rsel ? hi_q : lo_q;
    assign busy  = (state_q == StRun);

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed literal checks plus randomized traffic against an
// architectural model that tracks HI/LO, pending result and completion edge.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        rsel = 1'b0;
    logic [31:0] rdata;
    logic        busy;

    mdu #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .rsel (rsel),
        .rdata(rdata),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Architectural model: edge index, completion edge of the in-flight op.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int          m_edge = 0;
    int          m_until = 0;
    bit          m_pend = 1'b0;

    task automatic model_step();
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        m_edge++;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_pend = 1'b0; m_until = m_edge;
            return;
        end
        if (m_pend && m_edge == m_until) begin
            m_hi = m_phi; m_lo = m_plo; m_pend = 1'b0;
        end
        if (start && m_edge >= m_until) begin
            case (op)
                3'd1: begin
                    sp = longint'($signed(A)) * longint'($signed(B));
                    {m_phi, m_plo} = sp;
                    m_until = m_edge + MC; m_pend = 1'b1;
                end
                3'd2: begin
                    up = longint'({32'b0, A}) * longint'({32'b0, B});
                    {m_phi, m_plo} = up;
                    m_until = m_edge + MC; m_pend = 1'b1;
                end
                3'd3: begin
                    if (B == 32'd0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                        m_phi = 32'd0; m_plo = 32'h8000_0000;
                    end else begin
                        sa = $signed(A); sb = $signed(B);
                        m_plo = sa / sb; m_phi = sa % sb;
                    end
                    m_until = m_edge + DC; m_pend = 1'b1;
                end
                3'd4: begin
                    if (B == 32'd0) begin
                        m_phi = m_hi; m_plo = m_lo;
                    end else begin
                        m_plo = A / B; m_phi = A % B;
                    end
                    m_until = m_edge + DC; m_pend = 1'b1;
                end
                3'd5: m_hi = A;
                3'd6: m_lo = A;
                default: ;
            endcase
        end
    endtask

    // Every-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (busy !== m_pend) begin
                n_fail++;
                $display("FAIL busy@edge%0d: got %b expected %b", m_edge, busy, m_pend);
            end
            n_checks++;
            if (rdata !== (rsel ? m_hi : m_lo)) begin
                n_fail++;
                $display("FAIL rdata@edge%0d rsel=%b: got %h expected %h", m_edge, rsel, rdata,
                         rsel ? m_hi : m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic rs, input logic r);
        start = s; op = o; A = a; B = b; rsel = rs; rst = r;
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic h, output logic [31:0] v);
        rsel = h;
        #1;
        v = rdata;
    endtask

    task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] v;
        rd(1'b1, v);
        chk({name, " HI"}, v, eh);
        rd(1'b0, v);
        chk({name, " LO"}, v, el);
    endtask

    task automatic expect_op(input string name, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input int n, input logic [31:0] eh,
                             input logic [31:0] el);
        cyc(1'b1, o, a, b, 1'b0, 1'b0);
        chk({name, " busy after issue"}, {31'b0, busy}, 32'd1);
        for (int k = 1; k < n; k++) idle();
        chk({name, " busy last cycle"}, {31'b0, busy}, 32'd1);
        idle();
        chk({name, " busy done"}, {31'b0, busy}, 32'd0);
        check_hilo(name, eh, el);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);

        expect_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        expect_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h1);
        expect_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        expect_op("divu", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h8000_0000, 32'd0);
        expect_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);

        cyc(1'b1, 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        check_hilo("mthi/mtlo", 32'h11, 32'h22);
        expect_op("div0", 3'd3, 32'd5, 32'd0, DC, 32'h11, 32'h22);

        // Ignored MTHI in flight, then reset discards the multiply.
        cyc(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        idle();
        cyc(1'b1, 3'd5, 32'h55, 32'd0, 1'b1, 1'b0);
        check_hilo("ignored mthi", 32'h11, 32'h22);
        cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("reset in flight busy", {31'b0, busy}, 32'd0);
        check_hilo("reset in flight", 32'd0, 32'd0);
        for (int k = 0; k < 6; k++) idle();
        check_hilo("discarded mult", 32'd0, 32'd0);

        // Back-to-back: MTHI at the retire edge wins over the retired HI.
        cyc(1'b1, 3'd2, 32'd2, 32'd3, 1'b0, 1'b0);
        for (int k = 1; k < MC; k++) idle();
        cyc(1'b1, 3'd5, 32'h99, 32'd0, 1'b0, 1'b0);
        chk("b2b busy", {31'b0, busy}, 32'd0);
        check_hilo("b2b mthi", 32'h99, 32'd6);

        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_operand(),
                rnd_operand(), 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
